// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and valid/ready handshake.
// Configurable data width, parity, stop bits and baud divisor; all outputs registered.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               uart_tx,
    output logic                               busy,
    output logic                               char_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam int BIW = $clog2(DATA_BITS);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] BIT_LAST  = BIW'(DATA_BITS - 1);
    localparam logic [BIW-1:0] STOP_LAST = BIW'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // FIFO storage; pointers wrap naturally since depth is a power of 2
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count_q;
    logic                 push, pop;

    assign tx_ready   = (count_q < CW'(FIFO_DEPTH));
    assign fifo_count = count_q;
    assign push       = tx_valid && tx_ready;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Transmit FSM
    state_t               state_q, state_d;
    logic [BCW-1:0]       baud_q, baud_d;
    logic [BIW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_d, busy_d, done_d;
    logic                 baud_end, par_bit;

    assign baud_end = (baud_q == BAUD_LAST);
    assign par_bit  = (PARITY == 1) ? ~(^shift_d) : ^shift_d;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIW'(1);
                    end
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // chain straight into the next frame when data is waiting
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem[rd_ptr];
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIW'(1);
                    end
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from next-state values so they align with the state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[bit_d];
            S_PARITY: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            char_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            uart_tx   <= tx_d;
            busy      <= busy_d;
            char_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 7E1, 7O1 and 8N2 framing.
module tb_uart_tx_fifo;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic [7:0] d0, d3;
    logic [6:0] d1, d2;
    logic v0, v1, v2, v3;
    logic r0, r1, r2, r3;
    logic tx0, tx1, tx2, tx3;
    logic b0, b1, b2, b3;
    logic cd0, cd1, cd2, cd3;
    logic [2:0] fc0, fc1, fc2, fc3;

    int n_checks = 0;
    int n_fail   = 0;

    logic rec_tx [0:239];
    logic rec_b  [0:239];
    logic rec_cd [0:239];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clock(clock), .reset_n(reset_n), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
        .uart_tx(tx0), .busy(b0), .char_done(cd0), .fifo_count(fc0));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clock(clock), .reset_n(reset_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
        .uart_tx(tx1), .busy(b1), .char_done(cd1), .fifo_count(fc1));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clock(clock), .reset_n(reset_n), .tx_data(d2), .tx_valid(v2), .tx_ready(r2),
        .uart_tx(tx2), .busy(b2), .char_done(cd2), .fifo_count(fc2));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clock(clock), .reset_n(reset_n), .tx_data(d3), .tx_valid(v3), .tx_ready(r3),
        .uart_tx(tx3), .busy(b3), .char_done(cd3), .fifo_count(fc3));

    task automatic test_reset();
        reset_n = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tx0, r0, b0, cd0, fc0} !== {4'b1100, 3'd0}) begin
                n_fail++;
                $display("FAIL reset_idle_u0 cyc %0d: got tx/rdy/busy/done/cnt %b%b%b%b/%0d want 1100/0", i, tx0, r0, b0, cd0, fc0);
            end
            n_checks++;
            if ({tx1, tx2, tx3, r1, r2, r3, b1, b2, b3, fc1, fc2, fc3} !== {9'b111111000, 9'd0}) begin
                n_fail++;
                $display("FAIL reset_idle_others cyc %0d: got %b%b%b %b%b%b %b%b%b want 111 111 000", i, tx1, tx2, tx3, r1, r2, r3, b1, b2, b3);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] exp_line = 10'h34A;  // 0xA5 framed, index 0 = start bit
        @(negedge clock);
        d0 = 8'hA5; v0 = 1'b1;
        @(negedge clock);
        v0 = 1'b0;
        n_checks++;
        if ({tx0, fc0} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL single_after_push: got tx=%b cnt=%0d want tx=1 cnt=1", tx0, fc0);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_checks++;
            if (tx0 !== exp_line[i/4]) begin
                n_fail++;
                $display("FAIL single_line cyc %0d: got %b want %b", i, tx0, exp_line[i/4]);
            end
            n_checks++;
            if ({b0, cd0} !== {1'b1, (i == 39)}) begin
                n_fail++;
                $display("FAIL single_busy_done cyc %0d: got %b%b want 1%b", i, b0, cd0, (i == 39));
            end
        end
        @(negedge clock);
        n_checks++;
        if ({tx0, b0, cd0} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_end: got tx/busy/done %b%b%b want 100", tx0, b0, cd0);
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp_even = 10'h326;
        logic [10:0] exp_odd  = 10'h226;
        @(negedge clock);
        d1 = 7'h13; v1 = 1'b1;
        d2 = 7'h13; v2 = 1'b1;
        @(negedge clock);
        v1 = 1'b0; v2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_checks++;
            if (tx1 !== exp_even[i/4]) begin
                n_fail++;
                $display("FAIL parity_even cyc %0d: got %b want %b", i, tx1, exp_even[i/4]);
            end
            n_checks++;
            if (tx2 !== exp_odd[i/4]) begin
                n_fail++;
                $display("FAIL parity_odd cyc %0d: got %b want %b", i, tx2, exp_odd[i/4]);
            end
            n_checks++;
            if ({cd1, cd2} !== {2{i == 39}}) begin
                n_fail++;
                $display("FAIL parity_done cyc %0d: got %b%b want %b", i, cd1, cd2, (i == 39));
            end
        end
        @(negedge clock);
        n_checks++;
        if ({b1, b2, tx1, tx2} !== 4'b0011) begin
            n_fail++;
            $display("FAIL parity_end: got busy %b%b tx %b%b want 00 11", b1, b2, tx1, tx2);
        end
    endtask

    task automatic test_back_to_back();
        int  sent = 0;
        int  n_done = 0;
        logic saw_full = 1'b0;
        logic found = 1'b0;
        @(negedge clock);
        fork
            begin
                logic acc;
                d0 = 8'd1; v0 = 1'b1;
                for (int c = 0; c < 400 && sent < 6; c++) begin
                    acc = r0;
                    if (fc0 == 3'd4) saw_full = 1'b1;
                    n_checks++;
                    if (r0 !== (fc0 < 3'd4)) begin
                        n_fail++;
                        $display("FAIL burst_ready cyc %0d: got rdy=%b with cnt=%0d", c, r0, fc0);
                    end
                    @(negedge clock);
                    if (acc) begin
                        sent++;
                        d0 = 8'(sent + 1);
                        if (sent == 6) v0 = 1'b0;
                    end
                end
                v0 = 1'b0;
            end
            begin
                for (int c = 0; c < 60 && !found; c++) begin
                    @(negedge clock);
                    if (tx0 === 1'b0) found = 1'b1;
                end
                if (found) begin
                    rec_tx[0] = tx0; rec_b[0] = b0; rec_cd[0] = cd0;
                    for (int j = 1; j < 240; j++) begin
                        @(negedge clock);
                        rec_tx[j] = tx0; rec_b[j] = b0; rec_cd[j] = cd0;
                    end
                end
            end
        join
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL burst_start_timeout: got no start bit want start within 60 cycles");
        end
        n_checks++;
        if (sent != 6) begin
            n_fail++;
            $display("FAIL burst_accepted: got %0d want 6", sent);
        end
        n_checks++;
        if (saw_full !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_full: got saw_full=%b want 1", saw_full);
        end
        if (found) begin
            for (int c = 0; c < 240; c++) begin
                logic [7:0] byt;
                logic       e;
                int         bb;
                byt = 8'(c / 40 + 1);
                bb  = (c % 40) / 4;
                e   = (bb == 0) ? 1'b0 : (bb == 9) ? 1'b1 : byt[bb-1];
                if (rec_cd[c]) n_done++;
                n_checks++;
                if ({rec_tx[c], rec_b[c], rec_cd[c]} !== {e, 1'b1, (c % 40 == 39)}) begin
                    n_fail++;
                    $display("FAIL burst_frame cyc %0d: got tx/busy/done %b%b%b want %b1%b", c, rec_tx[c], rec_b[c], rec_cd[c], e, (c % 40 == 39));
                end
            end
            n_checks++;
            if (n_done != 6) begin
                n_fail++;
                $display("FAIL burst_done_count: got %0d want 6", n_done);
            end
        end
        @(negedge clock);
        n_checks++;
        if ({tx0, b0, fc0} !== {2'b10, 3'd0}) begin
            n_fail++;
            $display("FAIL burst_end: got tx=%b busy=%b cnt=%0d want 1 0 0", tx0, b0, fc0);
        end
    endtask

    task automatic test_two_stop();
        logic [15:0] dat = 16'hAA55;
        logic found = 1'b0;
        int   n_done = 0;
        @(negedge clock);
        d3 = 8'h55; v3 = 1'b1;
        @(negedge clock);
        d3 = 8'hAA;
        @(negedge clock);
        v3 = 1'b0;
        for (int c = 0; c < 60 && tx3 !== 1'b0; c++) @(negedge clock);
        found = (tx3 === 1'b0);
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stop2_start_timeout: got tx=%b want 0", tx3);
        end else begin
            for (int c = 0; c < 88; c++) begin
                logic e;
                int   bb;
                bb = (c % 44) / 4;
                e  = (bb == 0) ? 1'b0 : (bb >= 9) ? 1'b1 : dat[(c / 44) * 8 + bb - 1];
                if (cd3) n_done++;
                n_checks++;
                if ({tx3, b3, cd3} !== {e, 1'b1, (c % 44 == 43)}) begin
                    n_fail++;
                    $display("FAIL stop2_frame cyc %0d: got tx/busy/done %b%b%b want %b1%b", c, tx3, b3, cd3, e, (c % 44 == 43));
                end
                if (c < 87) @(negedge clock);
            end
            n_checks++;
            if (n_done != 2) begin
                n_fail++;
                $display("FAIL stop2_done_count: got %0d want 2", n_done);
            end
        end
        @(negedge clock);
        n_checks++;
        if ({tx3, b3} !== 2'b10) begin
            n_fail++;
            $display("FAIL stop2_end: got tx=%b busy=%b want 1 0", tx3, b3);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq [4] = '{8'hFF, 8'h01, 8'h02, 8'h03};
        @(negedge clock);
        v0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d0 = seq[i];
            @(negedge clock);
        end
        v0 = 1'b0;
        repeat (6) @(negedge clock);
        n_checks++;
        if ({b0, fc0} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL rstmid_before: got busy=%b cnt=%0d want 1 3", b0, fc0);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({tx0, b0, cd0, r0, fc0} !== {4'b1001, 3'd0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got tx/busy/done/rdy %b%b%b%b cnt=%0d want 1001 0", tx0, b0, cd0, r0, fc0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n_checks++;
            if ({tx0, b0, fc0} !== {2'b10, 3'd0}) begin
                n_fail++;
                $display("FAIL rstmid_after cyc %0d: got tx=%b busy=%b cnt=%0d want 1 0 0", i, tx0, b0, fc0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
